// File: rtl/prog_clkdiv_pkg.sv
// Shared constants and types for the programmable multi-channel clock divider.
package prog_clkdiv_pkg;

   localparam int unsigned DEF_CW       = 26;
   localparam int unsigned DEF_HALF_CYC = 25_000_000;

   typedef logic [DEF_CW-1:0] cnt_t;

   // Select-bus width for a given channel count (at least one bit).
   function automatic int unsigned sel_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prog_clkdiv_ch.sv
// One divider channel: half-period counter, output toggle and half-period load.
// Define PROG_CLKDIV_SHADOW_LOAD_EN to defer half-period writes to the next toggle.
module prog_clkdiv_ch
   import prog_clkdiv_pkg::*;
#(
   parameter int unsigned CW       = DEF_CW,
   parameter int unsigned DEF_HALF = DEF_HALF_CYC
) (
   input  logic          clk,
   input  logic          i_rst_n,
   input  logic          i_en,
   input  logic          i_align,
   input  logic          i_wr,
   input  logic [CW-1:0] i_wr_val,
   output logic          o_gclk,
   output logic          o_tick,
   output logic          o_pend
);

   logic [CW-1:0] r_hp;
   logic [CW-1:0] r_cnt;
   logic          r_gclk;
   logic          r_tick;
   logic [CW-1:0] w_hp_eff;
   logic          w_tc;

   // A zero half-period behaves as one, giving clk/2.
   assign w_hp_eff = (r_hp == '0) ? CW'(1) : r_hp;
   assign w_tc     = i_en && (r_cnt >= w_hp_eff);

`ifdef PROG_CLKDIV_SHADOW_LOAD_EN
   logic [CW-1:0] r_sh;
   logic          r_pend;

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_sh   <= '0;
         r_pend <= 1'b0;
      end else if (!i_align) begin
         if (w_tc) begin
            r_pend <= 1'b0;
         end else if (i_wr) begin
            r_sh   <= i_wr_val;
            r_pend <= 1'b1;
         end
      end
   end

   assign o_pend = r_pend;
`else
   assign o_pend = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_hp   <= CW'(DEF_HALF);
         r_cnt  <= CW'(1);
         r_gclk <= 1'b0;
         r_tick <= 1'b0;
      end else if (i_align) begin
         r_cnt  <= CW'(1);
         r_gclk <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_tc;
         if (w_tc) begin
            r_gclk <= ~r_gclk;
         end
`ifdef PROG_CLKDIV_SHADOW_LOAD_EN
         // Current half-period completes with the old value; new one takes effect at the toggle.
         if (w_tc) begin
            r_cnt <= CW'(1);
            if (i_wr) begin
               r_hp <= i_wr_val;
            end else if (r_pend) begin
               r_hp <= r_sh;
            end
         end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
         end
`else
         if (i_wr) begin
            r_hp  <= i_wr_val;
            r_cnt <= CW'(1);
         end else if (w_tc) begin
            r_cnt <= CW'(1);
         end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
         end
`endif
      end
   end

   assign o_gclk = r_gclk;
   assign o_tick = r_tick;

endmodule

// File: rtl/prog_clkdiv.sv
// Programmable multi-channel clock divider: write decode and align fan-out to NCH channels.
// Define PROG_CLKDIV_SHADOW_LOAD_EN for shadowed half-period loads.
module prog_clkdiv
   import prog_clkdiv_pkg::*;
#(
   parameter int unsigned NCH      = 2,
   parameter int unsigned CW       = DEF_CW,
   parameter int unsigned DEF_HALF = DEF_HALF_CYC
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NCH-1:0]          en,
   input  logic                    align,
   input  logic                    div_wr,
   input  logic [sel_w(NCH)-1:0]   div_sel,
   input  logic [CW-1:0]           div_val,
   output logic [NCH-1:0]          gclk,
   output logic [NCH-1:0]          tick,
   output logic [NCH-1:0]          pend
);

   localparam int unsigned SELW = sel_w(NCH);

   logic [NCH-1:0] w_wr;

   // Selects beyond the last channel match nothing and are dropped.
   always_comb begin
      w_wr = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (div_wr && (div_sel == SELW'(i))) begin
            w_wr[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      prog_clkdiv_ch #(
         .CW       (CW),
         .DEF_HALF (DEF_HALF)
      ) u_ch (
         .clk      (clk),
         .i_rst_n  (rst),
         .i_en     (en[g]),
         .i_align  (align),
         .i_wr     (w_wr[g]),
         .i_wr_val (div_val),
         .o_gclk   (gclk[g]),
         .o_tick   (tick[g]),
         .o_pend   (pend[g])
      );
   end

endmodule

// File: tb/tb_prog_clkdiv.sv
// Self-checking bench for prog_clkdiv (NCH=2, CW=8, DEF_HALF=3), scoreboard plus directed timing checks.
module tb_prog_clkdiv;

   localparam int NCH      = 2;
   localparam int CW       = 8;
   localparam int DEF_HALF = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] en;
   logic           align;
   logic           div_wr;
   logic [0:0]     div_sel;
   logic [CW-1:0]  div_val;
   logic [NCH-1:0] gclk;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] pend;

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];
   int n;

   int m_hp [NCH];
   int m_cnt[NCH];
   int m_sh [NCH];
   int m_g  [NCH];
   int m_t  [NCH];
   int m_p  [NCH];

   always #5 clk = ~clk;

   prog_clkdiv #(
      .NCH      (NCH),
      .CW       (CW),
      .DEF_HALF (DEF_HALF)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .align   (align),
      .div_wr  (div_wr),
      .div_sel (div_sel),
      .div_val (div_val),
      .gclk    (gclk),
      .tick    (tick),
      .pend    (pend)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference behaviour for one clock edge, using the inputs currently applied.
   task automatic model_step();
      int e;
      for (int i = 0; i < NCH; i++) begin
         int hpe;
         bit tc;
         bit wr;
         if (rst == 1'b0) begin
            m_hp[i] = DEF_HALF; m_cnt[i] = 1; m_g[i] = 0; m_t[i] = 0; m_p[i] = 0;
         end else if (align) begin
            m_cnt[i] = 1; m_g[i] = 0; m_t[i] = 0;
         end else begin
            hpe = (m_hp[i] == 0) ? 1 : m_hp[i];
            tc  = en[i] && (m_cnt[i] >= hpe);
            wr  = div_wr && (int'(div_sel) == i);
            m_t[i] = int'(tc);
`ifdef PROG_CLKDIV_SHADOW_LOAD_EN
            if (tc) begin
               m_g[i] ^= 1;
               m_cnt[i] = 1;
               if (wr) m_hp[i] = int'(div_val);
               else if (m_p[i] != 0) m_hp[i] = m_sh[i];
               m_p[i] = 0;
            end else begin
               if (en[i]) m_cnt[i]++;
               if (wr) begin m_sh[i] = int'(div_val); m_p[i] = 1; end
            end
`else
            if (tc) m_g[i] ^= 1;
            if (wr) begin m_hp[i] = int'(div_val); m_cnt[i] = 1; end
            else if (tc) m_cnt[i] = 1;
            else if (en[i]) m_cnt[i]++;
`endif
         end
      end
      e = 0;
      for (int i = 0; i < NCH; i++) begin
         e |= (m_g[i] << (4 + i)) | (m_t[i] << (2 + i)) | (m_p[i] << i);
      end
      exp_q.push_back(e);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("scoreboard", int'({gclk, tick, pend}), exp_q.pop_front());
   endtask

   task automatic wait_tick(input int ch, output int cnt);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         cycle();
         cnt++;
         if (tick[ch]) return;
      end
      chk("tick_timeout", 0, 1);
   endtask

   initial begin
      rst = 1'b0; en = '0; align = 1'b0; div_wr = 1'b0; div_sel = '0; div_val = '0;
      cycle();
      cycle();
      chk("rst_outputs", int'({gclk, tick, pend}), 0);

      // Release from reset: both channels rise together after 3 cycles, period 6.
      rst = 1'b1; en = 2'b11;
      wait_tick(0, n);
      chk("s1_first_half", n, 3);
      chk("s1_gclk_rise", int'(gclk), 3);
      chk("s1_tick_both", int'(tick), 3);
      wait_tick(0, n);
      chk("s1_second_half", n, 3);
      chk("s1_gclk_fall", int'(gclk), 0);

      // Write 5 to channel 1 while its count is 2.
      cycle();
      div_wr = 1'b1; div_sel = 1'b1; div_val = 8'd5;
      cycle();
      div_wr = 1'b0;
`ifdef PROG_CLKDIV_SHADOW_LOAD_EN
      chk("s2_pend_set", int'(pend), 2);
      wait_tick(1, n);
      chk("s2_old_half", n, 1);
`else
      chk("s2_pend_tied", int'(pend), 0);
      wait_tick(1, n);
      chk("s2_write_restart", n, 5);
`endif
      chk("s2_pend_clr", int'(pend), 0);
      wait_tick(1, n);
      chk("s2_new_half", n, 5);

      // Stall channel 0 for 4 cycles at count 2; the toggle slips by exactly that.
      wait_tick(0, n);
      cycle();
      en = 2'b10;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("s4_tick_off", int'(tick[0]), 0);
      end
      en = 2'b11;
      wait_tick(0, n);
      chk("s4_resume", n, 2);

      // Half-period 0 on channel 0 gives a toggle every cycle.
      div_wr = 1'b1; div_sel = 1'b0; div_val = 8'd0;
      cycle();
      div_wr = 1'b0;
      wait_tick(0, n);
`ifdef PROG_CLKDIV_SHADOW_LOAD_EN
      chk("s3_finish_half", n, 2);
`else
      chk("s3_immediate", n, 1);
`endif
      wait_tick(0, n);
      chk("s3_div2_a", n, 1);
      wait_tick(0, n);
      chk("s3_div2_b", n, 1);

      // Give channel 0 the same half-period as channel 1, then realign.
      div_wr = 1'b1; div_sel = 1'b0; div_val = 8'd5;
      cycle();
      div_wr = 1'b0;
      cycle(); cycle(); cycle();
      chk("s5_no_pend", int'(pend), 0);
      align = 1'b1;
      cycle();
      align = 1'b0;
      chk("s5_align_gclk", int'(gclk), 0);
      chk("s5_align_tick", int'(tick), 0);
      wait_tick(0, n);
      chk("s5_half", n, 5);
      chk("s5_coincide", int'(tick), 3);
      chk("s5_gclk_both", int'(gclk), 3);

      // Reset while channel 1 is high with a load pending.
      div_wr = 1'b1; div_sel = 1'b1; div_val = 8'd2;
      cycle();
      div_wr = 1'b0;
      chk("s6_gclk1_high", int'(gclk[1]), 1);
`ifdef PROG_CLKDIV_SHADOW_LOAD_EN
      chk("s6_pend1", int'(pend[1]), 1);
`endif
      rst = 1'b0;
      cycle();
      chk("s6_rst_outputs", int'({gclk, tick, pend}), 0);
      rst = 1'b1;
      wait_tick(1, n);
      chk("s6_hp_default", n, 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/prog_clkdiv.md
PROG_CLKDIV -- requirements
Module: prog_clkdiv

Interface
REQ-001 The block SHALL have parameter NCH, default 2: number of independent divider channels, 1..16.
REQ-002 The block SHALL have parameter CW, default 26: half-period counter width in bits.
REQ-003 The block SHALL have parameter DEF_HALF, default 25_000_000: reset half-period in clk cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port en, input, NCH bits: per-channel count enable.
REQ-007 The block SHALL have port align, input, 1 bit: one-cycle pulse that restarts all channels in phase.
REQ-008 The block SHALL have port div_wr, input, 1 bit: half-period write strobe.
REQ-009 The block SHALL have port div_sel, input, max(1,$clog2(NCH)) bits: target channel of the write.
REQ-010 The block SHALL have port div_val, input, CW bits: new half-period value.
REQ-011 The block SHALL have port gclk, output, NCH bits: registered divided clocks.
REQ-012 The block SHALL have port tick, output, NCH bits: one-cycle pulse, high in the cycle gclk[i] has just toggled.
REQ-013 The block SHALL have port pend, output, NCH bits: high while a shadow half-period load is waiting.

Function
REQ-014 Each channel i SHALL hold a half-period register hp[i], a counter cnt[i] and gclk[i].
REQ-015 With en[i]=1 and cnt[i]>=max(hp[i],1), the channel SHALL toggle gclk[i], set cnt[i]<=1 and drive tick[i]=1 on the next cycle; otherwise it SHALL set cnt[i]<=cnt[i]+1 and tick[i]=0.
REQ-016 The gclk[i] period SHALL be 2*max(hp[i],1) enabled cycles; hp=0 SHALL behave as hp=1, giving clk/2.
REQ-017 With en[i]=0, cnt[i] and gclk[i] SHALL hold their values and tick[i] SHALL be 0.
REQ-018 An align pulse SHALL set every cnt to 1, every gclk to 0 and every tick to 0, regardless of en; hp and pend SHALL be unaffected.
REQ-019 A div_wr with div_sel>=NCH SHALL be ignored.
REQ-020 Priority SHALL be rst, then align, then the write/count logic.
REQ-021 The counter SHALL never wrap; the >= compare SHALL guarantee a toggle even if hp drops below cnt.

Reset
REQ-022 While rst=0 at a clk edge, gclk, tick and pend SHALL be 0, every cnt SHALL be 1 and every hp SHALL be DEF_HALF truncated to CW bits.
REQ-023 Reset asserted mid-period SHALL take effect at the next edge, discarding partial counts and pending loads.

Configuration
REQ-024 With macro PROG_CLKDIV_SHADOW_LOAD_EN defined, a write SHALL go into shadow register sh[i] and set pend[i]=1.
REQ-025 With PROG_CLKDIV_SHADOW_LOAD_EN defined, hp[i]<=sh[i] and pend[i]<=0 SHALL occur at the next toggle of channel i, so the current half-period completes with the old value.
REQ-026 With PROG_CLKDIV_SHADOW_LOAD_EN defined, a write in the same cycle as a toggle SHALL load hp[i] at that toggle directly with pend[i]=0; a second write before the toggle SHALL overwrite sh[i].
REQ-027 Without PROG_CLKDIV_SHADOW_LOAD_EN, a write SHALL set hp[i]<=div_val and cnt[i]<=1 immediately; gclk[i] SHALL be unchanged unless that cycle is a toggle cycle, and pend SHALL be tied to 0.

Structure
REQ-028 Package prog_clkdiv_pkg SHALL hold the default CW and DEF_HALF constants and a counter typedef.
REQ-029 The per-channel counter, toggle and load logic SHALL be sub-module prog_clkdiv_ch, instantiated NCH times by a generate loop.
REQ-030 The top level SHALL contain only write decode and align fan-out.

Verification (NCH=2, CW=8, DEF_HALF=3, macro defined unless stated)
REQ-031 The bench SHALL check: release rst with en=2'b11 -> gclk[0]/gclk[1] rise together after 3 cycles, period 6, a tick every 3 cycles.
REQ-032 The bench SHALL check: write div_val=0 to ch0 -> after the current half-period, gclk[0] toggles every cycle.
REQ-033 The bench SHALL check: write 5 to ch1 at cnt=2 -> pend[1]=1, toggle at the old count of 3, pend[1]=0, then toggles every 5 cycles; without the macro, the next toggle comes 5 cycles after the write.
REQ-034 The bench SHALL check: en[0]=0 for 4 cycles at cnt=2 -> gclk[0] and the count hold, and the toggle is delayed by exactly 4 cycles.
REQ-035 The bench SHALL check: align pulse with channels out of phase -> both gclk=0 next cycle, and subsequent toggles coincide.
REQ-036 The bench SHALL check: rst=0 while gclk[1]=1 and pend[1]=1 -> next edge gclk=0, pend=0, hp reverts to 3.
